// File: rtl/interrupt_controller_if.sv
// interrupt_controller_if: I/O strobe bus between the control unit (master) and the interrupt controller (slave)
//   io_interrupt      interrupt request to the control unit
//   io_store_retaddr  capture d_bus as return address and accept the interrupt
//   io_push_retaddr   drive the stored return address on d_bus and end service
//   io_push_ints      drive the enabled pending requests on d_bus
//   io_push_int_addr  request the vector address on d_bus in the following cycle
//   io_addr_read      qualifies io_addr
//   io_addr           I/O register select
//   io_write          write the mask register from d_bus
//   io_push           read the mask register onto d_bus
interface interrupt_controller_if;
   logic       io_interrupt;
   logic       io_store_retaddr;
   logic       io_push_retaddr;
   logic       io_push_ints;
   logic       io_push_int_addr;
   logic       io_addr_read;
   logic [3:0] io_addr;
   logic       io_write;
   logic       io_push;
   modport slave (
      output io_interrupt,
      input  io_store_retaddr, io_push_retaddr, io_push_ints, io_push_int_addr,
      input  io_addr_read, io_addr, io_write, io_push
   );
   modport master (
      input  io_interrupt,
      output io_store_retaddr, io_push_retaddr, io_push_ints, io_push_int_addr,
      output io_addr_read, io_addr, io_write, io_push
   );
endinterface

// File: rtl/interrupt_controller.sv
// interrupt_controller: synchronises IRQ lines, masks pending requests and serves the control unit's interrupt strobes
//   clk    system clock, all state on posedge
//   rst_n  asynchronous active-low reset
//   irq    raw peripheral request lines, asynchronous to clk (line 0 = highest priority)
//   bus    I/O strobe bus (slave side), carries io_interrupt out and the io_* strobes in
//   d_bus  shared 16-bit data bus, high-Z unless a push strobe or the vector cycle drives it
// Define INTC_EDGE_DETECT_EN to latch rising edges as pending requests; otherwise the
// synchronised levels are the pending requests.
module interrupt_controller #(
   parameter int              N_IRQ       = 8,
   parameter logic [15:0]     VECTOR_BASE = 16'h0010,
   parameter logic [3:0]      IO_ADDR     = 4'hE,
   parameter logic [N_IRQ-1:0] MASK_RESET = {N_IRQ{1'b1}}
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_IRQ-1:0]     irq,
   interrupt_controller_if.slave bus,
   inout  wire  [15:0]          d_bus
);
   logic [N_IRQ-1:0] s1, s2, pending, mask, enabled;
   logic [15:0]      retaddr, drv_val;
   logic [3:0]       active_id, sel_id;
   logic             in_service, vec_drive, irq_out, accept, reg_sel, drv_en;
   assign enabled = pending & mask;
   assign accept  = bus.io_store_retaddr & ~in_service;
   assign reg_sel = bus.io_addr_read & (bus.io_addr == IO_ADDR);
   assign bus.io_interrupt = irq_out;
   // descending scan so the lowest enabled index is the one left standing
   always_comb begin
      sel_id = '0;
      for (int k = N_IRQ - 1; k >= 0; k--) if (enabled[k]) sel_id = 4'(k);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= irq;
         s2 <= s1;
      end
   end
`ifdef INTC_EDGE_DETECT_EN
   logic [N_IRQ-1:0] s3, clr;
   // only a real acceptance clears, so a masked request is never lost to an empty strobe
   always_comb begin
      clr = '0;
      for (int k = 0; k < N_IRQ; k++) clr[k] = accept & enabled[k] & (sel_id == 4'(k));
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s3      <= '0;
         pending <= '0;
      end else begin
         s3      <= s2;
         pending <= (pending & ~clr) | (s2 & ~s3);
      end
   end
`else
   assign pending = s2;
`endif
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mask       <= MASK_RESET;
         retaddr    <= '0;
         active_id  <= '0;
         in_service <= 1'b0;
         vec_drive  <= 1'b0;
         irq_out    <= 1'b0;
      end else begin
         irq_out    <= |enabled & ~in_service;
         vec_drive  <= bus.io_push_int_addr;
         in_service <= accept | (in_service & ~bus.io_push_retaddr);
         if (accept) begin
            retaddr   <= d_bus;
            active_id <= sel_id;
         end
         if (bus.io_write & reg_sel) mask <= d_bus[N_IRQ-1:0];
      end
   end
   // one priority chain feeds a single driver, so overlapping strobes can never contend
   assign drv_en  = rst_n & (vec_drive | bus.io_push_retaddr | bus.io_push_ints | (bus.io_push & reg_sel));
   assign drv_val = vec_drive            ? VECTOR_BASE + 16'(active_id) :
                    bus.io_push_retaddr ? retaddr :
                    bus.io_push_ints    ? 16'(enabled) : 16'(mask);
   assign d_bus   = drv_en ? drv_val : 16'hzzzz;
endmodule
